// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// spi_xfer_ctrl: SPI master word sequencer (IDLE/SETUP/XFER/HOLD) that shifts
// data on externally generated sample/shift strobes from a baud-rate generator.
module spi_xfer_ctrl #(
  parameter int DATA_W   = 8,
  parameter int HOLD_CYC = 2
) (
  input  logic              PClk,
  input  logic              PRESET,
  input  logic              spe,
  input  logic              cpha,
  input  logic              lsbfe,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  input  logic              sample_pulse,
  input  logic              shift_pulse,
  input  logic              miso,
  output logic              ss,
  output logic              mosi,
  output logic              sclk_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int HOLD_W = 4;
  localparam logic [CNT_W-1:0]  BIT_FULL  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] tx_shreg;
  logic [DATA_W-1:0] rx_shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              lsbfe_q;
  logic              skip_shift;
  logic              accept;
  logic              do_sample;
  logic              shift_seen;
  logic              last_sample;
  logic              hold_done;

  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = (state == IDLE) && spe && tx_valid;
    do_sample   = (state == XFER) && spe && sample_pulse && (bit_cnt < BIT_FULL);
    shift_seen  = (state == XFER) && spe && shift_pulse && (bit_cnt < BIT_FULL);
    last_sample = do_sample && (bit_cnt == BIT_LAST);
    hold_done   = (state == HOLD) && (hold_cnt == HOLD_LAST);
    tx_ready    = (state == IDLE) && spe;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = XFER;
      XFER:    if (last_sample) state_nxt = HOLD;
      HOLD:    if (hold_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Losing the enable abandons whatever is in flight.
    if (!spe) state_nxt = IDLE;
  end

  always_ff @(posedge PClk or posedge PRESET) begin
    if (PRESET) begin
      ss         <= 1'b1;
      mosi       <= 1'b0;
      sclk_en    <= 1'b0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      tx_shreg   <= '0;
      rx_shreg   <= '0;
      bit_cnt    <= '0;
      hold_cnt   <= '0;
      lsbfe_q    <= 1'b0;
      skip_shift <= 1'b0;
    end else begin
      ss       <= (state_nxt == IDLE);
      sclk_en  <= (state_nxt == XFER);
      rx_valid <= hold_done && spe;
      hold_cnt <= (state == HOLD) ? hold_cnt + HOLD_ONE : '0;
      if (hold_done && spe) rx_data <= rx_shreg;

      if (accept) begin
        tx_shreg   <= tx_data;
        rx_shreg   <= '0;
        bit_cnt    <= '0;
        lsbfe_q    <= lsbfe;
        skip_shift <= cpha;
        mosi       <= lsbfe ? tx_data[0] : tx_data[DATA_W-1];
      end

      if (do_sample) begin
        bit_cnt  <= bit_cnt + CNT_ONE;
        rx_shreg <= lsbfe_q ? {miso, rx_shreg[DATA_W-1:1]}
                            : {rx_shreg[DATA_W-2:0], miso};
      end

      // With cpha=1 the first shift strobe is the leading edge that precedes
      // the first sample, so the first bit must stay on the line.
      if (shift_seen) begin
        if (skip_shift) begin
          skip_shift <= 1'b0;
        end else if (lsbfe_q) begin
          tx_shreg <= {1'b0, tx_shreg[DATA_W-1:1]};
          mosi     <= tx_shreg[1];
        end else begin
          tx_shreg <= {tx_shreg[DATA_W-2:0], 1'b0};
          mosi     <= tx_shreg[DATA_W-2];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// tb_spi_xfer_ctrl: table-driven transfers with a receive scoreboard, plus
// abort, asynchronous reset and back-to-back sequences.
module tb_spi_xfer_ctrl;

  localparam int DATA_W   = 8;
  localparam int HOLD_CYC = 2;

  logic              PClk = 1'b0;
  logic              PRESET;
  logic              spe;
  logic              cpha;
  logic              lsbfe;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              sample_pulse;
  logic              shift_pulse;
  logic              miso;
  logic              ss;
  logic              mosi;
  logic              sclk_en;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  spi_xfer_ctrl #(.DATA_W(DATA_W), .HOLD_CYC(HOLD_CYC)) dut (
    .PClk(PClk), .PRESET(PRESET), .spe(spe), .cpha(cpha), .lsbfe(lsbfe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .sample_pulse(sample_pulse), .shift_pulse(shift_pulse), .miso(miso),
    .ss(ss), .mosi(mosi), .sclk_en(sclk_en), .rx_data(rx_data),
    .rx_valid(rx_valid), .busy(busy)
  );

  always #5 PClk = ~PClk;

  typedef struct {
    logic       cpha;
    logic       lsbfe;
    logic       coinc;
    logic       loop;
    logic [7:0] tx;
    logic [7:0] miso_w;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] scb[$];
  int         checks = 0;
  int         failures = 0;
  int         sslow = 0;
  int         ready_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge PClk);
    if (ss === 1'b0) sslow++;
    if (tx_ready === 1'b1 && (ss === 1'b0 || busy === 1'b1)) ready_bad++;
  endtask

  always @(negedge PClk) begin
    if (rx_valid === 1'b1) begin
      if (scb.size() == 0) begin
        check("rx_valid_with_nothing_pending", rx_valid, 1'b0);
      end else begin
        automatic logic [7:0] e = scb.pop_front();
        check("scoreboard_rx_data", rx_data, e);
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while (ss !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check({tag, ".ss_back_high"}, ss, 1'b1);
  endtask

  // Drives the strobe pattern from the first XFER cycle; records mosi at each sample.
  task automatic serve(input vec_t v, input string tag, output logic [7:0] mseq, output int xfer_cyc);
    logic [1:0] ev[$];
    int n = 0;
    int last = 0;
    mseq = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (v.coinc) ev.push_back(2'b11);
      else if (v.cpha) begin ev.push_back(2'b01); ev.push_back(2'b10); end
      else begin ev.push_back(2'b10); ev.push_back(2'b01); end
    end
    foreach (ev[j]) begin
      tick();
      if (j == 0) check({tag, ".sclk_en_xfer"}, sclk_en, 1'b1);
      if (ev[j][1]) begin
        mseq = {mseq[6:0], mosi};
        miso = v.loop ? mosi : (v.lsbfe ? v.miso_w[n] : v.miso_w[7-n]);
        n++;
        last = 2 * j;
      end
      sample_pulse = ev[j][1];
      shift_pulse  = ev[j][0];
      tick();
      sample_pulse = 1'b0;
      shift_pulse  = 1'b0;
    end
    xfer_cyc = last + 1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic [7:0] mseq;
    int xc;
    sslow    = 0;
    tx_data  = v.tx;
    tx_valid = 1'b1;
    cpha     = v.cpha;
    lsbfe    = v.lsbfe;
    scb.push_back(v.exp_rx);
    tick();
    check({tag, ".ss_setup"}, ss, 1'b0);
    check({tag, ".sclk_en_setup"}, sclk_en, 1'b0);
    check({tag, ".mosi_first"}, mosi, v.lsbfe ? v.tx[0] : v.tx[7]);
    check({tag, ".tx_ready_setup"}, tx_ready, 1'b0);
    tx_valid = 1'b0;
    cpha     = ~v.cpha;
    lsbfe    = ~v.lsbfe;
    serve(v, tag, mseq, xc);
    wait_idle(tag);
    check({tag, ".rx_valid"}, rx_valid, 1'b1);
    check({tag, ".mosi_seq"}, mseq, v.exp_mosi);
    check({tag, ".ss_low_cycles"}, sslow, 1 + xc + HOLD_CYC);
    tick();
    check({tag, ".rx_valid_one_cycle"}, rx_valid, 1'b0);
    check({tag, ".rx_data_held"}, rx_data, v.exp_rx);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t b;
    logic [7:0] mseq;
    int xc;
    //          cpha  lsbfe coinc loop  tx     miso   exp_rx exp_mosi
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h81, 8'h81, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 8'h00, 8'hA5, 8'hA5};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h96, 8'h5A, 8'h5A, 8'h69};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h0F, 8'hF0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 8'hC3, 8'hC3, 8'h3C};

    spe = 1'b1; cpha = 1'b0; lsbfe = 1'b0; tx_valid = 1'b0; tx_data = '0;
    sample_pulse = 1'b0; shift_pulse = 1'b0; miso = 1'b0;
    PRESET = 1'b0;
    #1 PRESET = 1'b1;
    #3;
    check("reset.ss", ss, 1'b1);
    check("reset.mosi", mosi, 1'b0);
    check("reset.sclk_en", sclk_en, 1'b0);
    check("reset.rx_valid", rx_valid, 1'b0);
    check("reset.rx_data", rx_data, 8'h00);
    check("reset.busy", busy, 1'b0);
    check("reset.tx_ready", tx_ready, 1'b1);
    @(negedge PClk);
    PRESET = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // spe dropped after three samples
    cpha = 1'b0; lsbfe = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); miso = mosi; sample_pulse = 1'b1;
      tick(); sample_pulse = 1'b0;
    end
    spe = 1'b0;
    tick();
    check("abort.busy", busy, 1'b0);
    check("abort.ss", ss, 1'b1);
    check("abort.sclk_en", sclk_en, 1'b0);
    check("abort.tx_ready_spe_low", tx_ready, 1'b0);
    repeat (6) tick();
    check("abort.rx_data_kept", rx_data, 8'hC3);
    spe = 1'b1;
    run_vec(vecs[0], "after_abort");

    // two queued words with tx_valid held high
    ready_bad = 0;
    b = vecs[0]; b.tx = 8'h5A; b.exp_rx = 8'h5A; b.exp_mosi = 8'h5A;
    cpha = 1'b0; lsbfe = 1'b0; tx_data = 8'h5A; tx_valid = 1'b1;
    scb.push_back(8'h5A);
    tick();
    check("b2b.tx_ready_setup", tx_ready, 1'b0);
    tx_data = 8'hC3;
    serve(b, "b2b_w1", mseq, xc);
    wait_idle("b2b_w1");
    check("b2b.first_rx_valid", rx_valid, 1'b1);
    check("b2b.first_rx_data", rx_data, 8'h5A);
    check("b2b.tx_ready_idle", tx_ready, 1'b1);
    scb.push_back(8'hC3);
    tick();
    check("b2b.second_started", busy, 1'b1);
    check("b2b.second_ss", ss, 1'b0);
    tx_valid = 1'b0;
    b.tx = 8'hC3; b.exp_rx = 8'hC3; b.exp_mosi = 8'hC3;
    serve(b, "b2b_w2", mseq, xc);
    check("b2b.second_mosi_seq", mseq, 8'hC3);
    wait_idle("b2b_w2");
    check("b2b.second_rx_valid", rx_valid, 1'b1);
    tick();
    check("b2b.tx_ready_low_while_active", ready_bad, 0);

    // asynchronous reset in the middle of XFER
    tx_data = 8'hFF; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick(); miso = 1'b1; sample_pulse = 1'b1;
    tick(); sample_pulse = 1'b0;
    check("areset.in_xfer", sclk_en, 1'b1);
    #2 PRESET = 1'b1;
    #1;
    check("areset.ss", ss, 1'b1);
    check("areset.sclk_en", sclk_en, 1'b0);
    check("areset.busy", busy, 1'b0);
    check("areset.rx_data", rx_data, 8'h00);
    check("areset.mosi", mosi, 1'b0);
    #1 PRESET = 1'b0;
    repeat (40) tick();
    check("areset.stays_idle", busy, 1'b0);

    check("scoreboard_drained", scb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer (legal 4..16).
REQ-002 SHALL have parameter HOLD_CYC, default 2, meaning PClk cycles SS stays low after the last sample (legal 1..15).
REQ-003 SHALL have port PClk, input, 1, meaning the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port PRESET, input, 1, meaning an asynchronous active-high reset.
REQ-005 SHALL have port spe, input, 1, meaning the SPI enable; 0 aborts any transfer and blocks new ones.
REQ-006 SHALL have ports cpha and lsbfe, input, 1 each, meaning clock phase and LSB-first select; both are sampled only at transfer start.
REQ-007 SHALL have ports tx_valid (input, 1), tx_data (input, DATA_W) and tx_ready (output, 1), meaning a valid/ready transmit handshake.
REQ-008 SHALL have ports sample_pulse and shift_pulse, input, 1 each, meaning single-PClk phase-correct edge strobes from the baud rate generator.
REQ-009 SHALL have port miso, input, 1, meaning serial receive data.
REQ-010 SHALL have port ss, output, 1, meaning the active-low slave select.
REQ-011 SHALL have port mosi, output, 1, meaning serial transmit data.
REQ-012 SHALL have port sclk_en, output, 1, meaning the baud generator run enable.
REQ-013 SHALL have ports rx_data (output, DATA_W) and rx_valid (output, 1), meaning the received word and its one-cycle strobe.
REQ-014 SHALL have port busy, output, 1, meaning state != IDLE.

Function
REQ-015 SHALL implement states IDLE, SETUP, XFER and HOLD.
REQ-016 IDLE behaviour SHALL be:
- ss=1, sclk_en=0, tx_ready=spe.
- tx_valid & tx_ready loads tx_data into tx_shreg, latches cpha/lsbfe, clears bit_cnt, and goes to SETUP.
REQ-017 SETUP SHALL last exactly 1 cycle with ss=0, sclk_en=0, and mosi = first bit (tx_shreg[DATA_W-1], or [0] if lsbfe), then go to XFER.
REQ-018 XFER SHALL hold ss=0 and sclk_en=1.
REQ-019 In XFER, each sample_pulse SHALL shift miso into rx_shreg (at the LSB end if lsbfe=0, at the MSB end if lsbfe=1) and increment bit_cnt.
REQ-020 In XFER, each shift_pulse SHALL advance mosi to the next bit, except that with latched cpha=1 the first shift_pulse of a transfer does not advance.
REQ-021 When sample_pulse and shift_pulse coincide, both actions SHALL occur in the same cycle, with the sample taking the pre-shift miso.
REQ-022 The sample_pulse that makes bit_cnt == DATA_W SHALL transition to HOLD on the next edge; shift_pulses after that point SHALL be ignored.
REQ-023 HOLD behaviour SHALL be:
- ss=0, sclk_en=0, and mosi holds its value.
- A hold counter runs for HOLD_CYC cycles.
- The design then goes to IDLE with ss=1.
REQ-024 rx_data SHALL update and rx_valid SHALL pulse for exactly 1 cycle on the HOLD->IDLE edge.
REQ-025 rx_data SHALL hold its value until the next completed transfer.
REQ-026 tx_ready SHALL be 0 in every state other than IDLE, so that back-to-back words spend at least 1 cycle in IDLE.
REQ-027 spe=0 in SETUP, XFER or HOLD SHALL force the next state to IDLE, with no rx_valid and rx_data unchanged.
REQ-028 Pulses seen in IDLE, SETUP or HOLD SHALL have no effect.
REQ-029 bit_cnt SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap.
REQ-030 All outputs SHALL be registered, except tx_ready and busy, which are decoded from state.

Reset
REQ-031 While PRESET=1, and immediately on its assertion, the block SHALL force:
- state=IDLE, ss=1, mosi=0, sclk_en=0, rx_valid=0.
- rx_data=0, tx_shreg=0, rx_shreg=0, bit_cnt=0, hold counter=0.
REQ-032 PRESET asserted mid-transfer SHALL abort the transfer with no rx_valid.
REQ-033 After PRESET is deasserted, the first transfer SHALL be accepted no earlier than the first PClk edge.

Verification
REQ-034 SHALL cover: DATA_W=8, cpha=0, lsbfe=0, tx_data=0xA5, miso looped to mosi -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0xA5; rx_valid high 1 cycle; ss low for 1+XFER+2 cycles.
REQ-035 SHALL cover: cpha=1, lsbfe=1, tx_data=0x3C, miso driven as the bits of 0x81 LSB-first -> first shift_pulse does not advance mosi; mosi sequence 0,0,1,1,1,1,0,0; rx_data=0x81.
REQ-036 SHALL cover: sample_pulse and shift_pulse asserted in the same cycle throughout a transfer -> all DATA_W bits are both sampled and shifted; result matches the non-coincident case.
REQ-037 SHALL cover: spe dropped after 3 samples -> next cycle is IDLE, ss=1, no rx_valid, rx_data keeps its prior value; a new transfer then completes normally.
REQ-038 SHALL cover: PRESET pulsed asynchronously (between PClk edges) during XFER -> ss=1 and sclk_en=0 before the next PClk edge; no rx_valid is ever produced for that transfer.
REQ-039 SHALL cover: tx_valid held high continuously with two queued words -> tx_ready=0 from SETUP to IDLE; the second word starts after rx_valid for the first, with ss going high for at least 1 cycle in between.
